// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, branch redirect, and the decode handshake.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 24
);
    logic [ADDR_W-1:0]  instr_addr;
    logic [INSTR_W-1:0] instr_word;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [INSTR_W-1:0] fetch_instr;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               halted;

    modport master (
        output instr_addr, fetch_valid, fetch_instr, fetch_pc, halted,
        input  instr_word, branch_en, branch_target, fetch_ready
    );

    modport slave (
        input  instr_addr, fetch_valid, fetch_instr, fetch_pc, halted,
        output instr_word, branch_en, branch_target, fetch_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC and fetch register feeding decode through a valid/ready handshake, with branch redirect.
// Optional halt opcode (top byte 8'hFF) is enabled by defining INSTR_FETCH_HALT_EN.
module instruction_fetch #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 24
) (
    input logic                clk,
    input logic                reset_n,
    instruction_fetch_if.master bus
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic               running;
    logic               halt_word;

`ifdef INSTR_FETCH_HALT_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state_q, state_d;

    assign running    = (state_q == RUN);
    assign halt_word  = (bus.instr_word[INSTR_W-1 -: 8] == 8'hFF);
    assign bus.halted = (state_q == HALT);
`else
    assign running    = 1'b1;
    assign halt_word  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    assign bus.instr_addr  = pc_q;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_instr = instr_q;
    assign bus.fetch_pc    = fpc_q;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;
`ifdef INSTR_FETCH_HALT_EN
        state_d = state_q;
`endif
        if (bus.branch_en) begin
            pc_d    = bus.branch_target;
            valid_d = 1'b0;
`ifdef INSTR_FETCH_HALT_EN
            state_d = RUN;
`endif
        end else if (running && (!valid_q || bus.fetch_ready)) begin
            instr_d = bus.instr_word;
            fpc_d   = pc_q;
            valid_d = 1'b1;
            // A halt word is presented but the PC stays parked on it.
            if (halt_word) begin
`ifdef INSTR_FETCH_HALT_EN
                state_d = HALT;
`endif
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end else if (!running && valid_q && bus.fetch_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            fpc_q   <= '0;
`ifdef INSTR_FETCH_HALT_EN
            state_q <= RUN;
`endif
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
`ifdef INSTR_FETCH_HALT_EN
            state_q <= state_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, halt sequence, and random run vs a reference model.
module tb_instruction_fetch;

`ifdef INSTR_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    logic [23:0] mem [64];

    int total;
    int bad;

    // reference model state
    int          m_pc;
    logic        m_valid;
    logic [23:0] m_instr;
    int          m_fpc;
    logic        m_halted;

    instruction_fetch_if #(.ADDR_W(6), .INSTR_W(24)) bus ();

    instruction_fetch #(.ADDR_W(6), .INSTR_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.instr_word = mem[bus.instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        br;
        logic [5:0]  tgt;
        logic        rdy;
        logic        exp_valid;
        logic [5:0]  exp_fpc;
        logic [23:0] exp_instr;
        logic [5:0]  exp_addr;
    } vec_t;

    vec_t vecs [23];

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model follows the fetch rules directly: flush on branch, fetch when the slot frees up,
    // drain the last word while halted.
    task automatic step_model(input logic rst_n, input logic br, input logic [5:0] tgt, input logic rdy);
        logic [23:0] word;
        if (!rst_n) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_fpc = 0; m_halted = 0;
        end else if (br) begin
            m_pc = int'(tgt); m_valid = 0; m_halted = 0;
        end else if (!m_halted && (!m_valid || rdy)) begin
            word    = mem[m_pc];
            m_instr = word;
            m_fpc   = m_pc;
            m_valid = 1;
            if (HALT_EN && word[23:16] == 8'hFF) m_halted = 1;
            else m_pc = (m_pc + 1) % 64;
        end else if (m_halted && m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic apply_stimulus(input logic rst_n, input logic br, input logic [5:0] tgt, input logic rdy);
        reset_n           = rst_n;
        bus.branch_en     = br;
        bus.branch_target = tgt;
        bus.fetch_ready   = rdy;
        step_model(rst_n, br, tgt, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag);
        check_value({tag, ".addr"},   32'(bus.instr_addr),  32'(m_pc));
        check_value({tag, ".valid"},  32'(bus.fetch_valid), 32'(m_valid));
        check_value({tag, ".instr"},  32'(bus.fetch_instr), 32'(m_instr));
        check_value({tag, ".fpc"},    32'(bus.fetch_pc),    32'(m_fpc));
        check_value({tag, ".halted"}, 32'(bus.halted),      32'(m_halted));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_pc = 0; m_valid = 0; m_instr = 0; m_fpc = 0; m_halted = 0;
        reset_n = 1'b0;
        bus.branch_en = 1'b0;
        bus.branch_target = '0;
        bus.fetch_ready = 1'b0;

        mem[0] = 24'hC0003A; mem[1] = 24'hC10059; mem[2] = 24'h120100; mem[3] = 24'hE20001;
        mem[4] = 24'hC30014; mem[5] = 24'h242300; mem[6] = 24'hE40002; mem[7] = 24'hF1C000;
        for (int i = 8; i < 64; i++) mem[i] = 24'h500000 | 24'(i);

        // rst_n br tgt rdy | valid fpc instr addr
        vecs[0]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 24'h000000, 6'h00};
        vecs[1]  = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h00, 24'hC0003A, 6'h01};
        vecs[2]  = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h01, 24'hC10059, 6'h02};
        vecs[3]  = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h02, 24'h120100, 6'h03};
        vecs[4]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h02, 24'h120100, 6'h03};
        vecs[5]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h02, 24'h120100, 6'h03};
        vecs[6]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h02, 24'h120100, 6'h03};
        vecs[7]  = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h03, 24'hE20001, 6'h04};
        vecs[8]  = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h04, 24'hC30014, 6'h05};
        vecs[9]  = '{1'b1, 1'b1, 6'h01, 1'b1, 1'b0, 6'h04, 24'hC30014, 6'h01};
        vecs[10] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h01, 24'hC10059, 6'h02};
        vecs[11] = '{1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 6'h01, 24'hC10059, 6'h05};
        vecs[12] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h05, 24'h242300, 6'h06};
        vecs[13] = '{1'b1, 1'b1, 6'h3F, 1'b1, 1'b0, 6'h05, 24'h242300, 6'h3F};
        vecs[14] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 24'h50003F, 6'h00};
        vecs[15] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h00, 24'hC0003A, 6'h01};
        vecs[16] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h01, 24'hC10059, 6'h02};
        vecs[17] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h02, 24'h120100, 6'h03};
        vecs[18] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h03, 24'hE20001, 6'h04};
        vecs[19] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h04, 24'hC30014, 6'h05};
        vecs[20] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h05, 24'h242300, 6'h06};
        vecs[21] = '{1'b0, 1'b1, 6'h15, 1'b1, 1'b0, 6'h00, 24'h000000, 6'h00};
        vecs[22] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h00, 24'hC0003A, 6'h01};

        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
            check_value($sformatf("vec%0d.valid", i), 32'(bus.fetch_valid), 32'(vecs[i].exp_valid));
            check_value($sformatf("vec%0d.fpc", i),   32'(bus.fetch_pc),    32'(vecs[i].exp_fpc));
            check_value($sformatf("vec%0d.instr", i), 32'(bus.fetch_instr), 32'(vecs[i].exp_instr));
            check_value($sformatf("vec%0d.addr", i),  32'(bus.instr_addr),  32'(vecs[i].exp_addr));
            check_value($sformatf("vec%0d.halted", i), 32'(bus.halted),     32'd0);
        end

        // Halt word at address 4.
        mem[4] = 24'hFF0000;
        apply_stimulus(1'b0, 1'b0, 6'h00, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 6'h00, 1'b1);
        check_value("halt.fpc",   32'(bus.fetch_pc),    32'h4);
        check_value("halt.instr", 32'(bus.fetch_instr), 32'hFF0000);
        check_value("halt.valid", 32'(bus.fetch_valid), 32'h1);
`ifdef INSTR_FETCH_HALT_EN
        check_value("halt.halted", 32'(bus.halted),     32'h1);
        check_value("halt.addr",   32'(bus.instr_addr), 32'h4);
        apply_stimulus(1'b1, 1'b0, 6'h00, 1'b1);
        check_value("halt.drain_valid", 32'(bus.fetch_valid), 32'h0);
        check_value("halt.drain_addr",  32'(bus.instr_addr),  32'h4);
        apply_stimulus(1'b1, 1'b0, 6'h00, 1'b1);
        check_value("halt.idle_valid",  32'(bus.fetch_valid), 32'h0);
        check_value("halt.idle_halted", 32'(bus.halted),      32'h1);
        apply_stimulus(1'b1, 1'b1, 6'h00, 1'b1);
        check_value("halt.exit_halted", 32'(bus.halted),      32'h0);
        check_value("halt.exit_addr",   32'(bus.instr_addr),  32'h0);
        apply_stimulus(1'b1, 1'b0, 6'h00, 1'b1);
        check_value("halt.resume_valid", 32'(bus.fetch_valid), 32'h1);
        check_value("halt.resume_instr", 32'(bus.fetch_instr), 32'hC0003A);
`else
        check_value("nohalt.halted", 32'(bus.halted),     32'h0);
        check_value("nohalt.addr",   32'(bus.instr_addr), 32'h5);
        apply_stimulus(1'b1, 1'b0, 6'h00, 1'b1);
        check_value("nohalt.fpc",    32'(bus.fetch_pc),    32'h5);
        check_value("nohalt.instr",  32'(bus.fetch_instr), 32'h242300);
`endif
        check_output("post_halt");

        // Random memory (with occasional halt words) and random control.
        for (int i = 0; i < 64; i++) begin
            mem[i] = 24'($urandom);
            if ($urandom_range(0, 9) == 0) mem[i][23:16] = 8'hFF;
        end
        apply_stimulus(1'b0, 1'b0, 6'h00, 1'b0);
        check_output("rnd_reset");
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 49) != 0,
                           $urandom_range(0, 9) == 0,
                           6'($urandom),
                           $urandom_range(0, 9) < 7);
            check_output($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
